program_sequencer: RTL and testbench

Parametrised program counter with absolute jump, PC-relative branch, and subroutine call/return backed by a hardware return-address stack. It replaces the fixed 8-bit increment-only counter as the instruction-fetch address source for ROM. The control unit issues one command per cycle. It sits between the control unit and the instruction memory address port.

---
 rtl/program_sequencer_if.sv | 33 +++
 rtl/program_sequencer.sv | 159 +++++++++++++++
 tb/tb_program_sequencer.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/program_sequencer_if.sv
// Command/status bundle between the control unit (master) and the program sequencer (slave).
// Widths follow ADDR_W and STACK_DEPTH so both ends agree on pc and stack_count sizes.
interface program_sequencer_if #(
   parameter int ADDR_W      = 8,
   parameter int STACK_DEPTH = 4
);
   localparam int CNT_W = $clog2(STACK_DEPTH + 1);

   logic              enable_increment;
   logic              jump;
   logic              branch;
   logic              call;
   logic              ret;
   logic              clear_err;
   logic [ADDR_W-1:0] target;
   logic [ADDR_W-1:0] offset;
   logic [ADDR_W-1:0] pc;
   logic [CNT_W-1:0]  stack_count;
   logic              stack_full;
   logic              stack_empty;
   logic              overflow;
   logic              underflow;

   modport master (
      output enable_increment, jump, branch, call, ret, clear_err, target, offset,
      input  pc, stack_count, stack_full, stack_empty, overflow, underflow
   );

   modport slave (
      input  enable_increment, jump, branch, call, ret, clear_err, target, offset,
      output pc, stack_count, stack_full, stack_empty, overflow, underflow
   );
endinterface

// File: rtl/program_sequencer.sv
// Program counter with increment, jump, relative branch and call/return on falling clk edges.
// Return-address stack and its flags exist only when PC_RETURN_STACK_EN is defined.
module program_sequencer #(
   parameter int                 ADDR_W      = 8,
   parameter logic [ADDR_W-1:0]  RESET_ADDR  = '0,
   parameter int                 STACK_DEPTH = 4
) (
   input logic                clk,
   input logic                reset,
   program_sequencer_if.slave bus
);
   localparam int CNT_W = $clog2(STACK_DEPTH + 1);
   localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   typedef enum logic [2:0] {
      CMD_HOLD,
      CMD_INC,
      CMD_BRANCH,
      CMD_JUMP,
      CMD_CALL,
      CMD_RET
   } cmd_e;

   function automatic logic [ADDR_W-1:0] wrap_add(input logic [ADDR_W-1:0]        base,
                                                  input logic signed [ADDR_W-1:0] disp);
      return base + ADDR_W'($unsigned(disp));
   endfunction

   cmd_e                     cmd;
   logic [ADDR_W-1:0]        pc_r;
   logic [ADDR_W-1:0]        pc_nxt;
   logic [ADDR_W-1:0]        pc_inc;
   logic signed [ADDR_W-1:0] offset_s;

   assign offset_s = signed'(bus.offset);
   assign pc_inc   = wrap_add(pc_r, ADDR_W'(1));

   // Highest-priority asserted command wins; the rest are dropped this cycle.
   always_comb begin
      cmd = CMD_HOLD;
      if (bus.ret)                   cmd = CMD_RET;
      else if (bus.call)             cmd = CMD_CALL;
      else if (bus.jump)             cmd = CMD_JUMP;
      else if (bus.branch)           cmd = CMD_BRANCH;
      else if (bus.enable_increment) cmd = CMD_INC;
   end

`ifdef PC_RETURN_STACK_EN
   logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];
   logic [CNT_W-1:0]  count_r;
   logic [CNT_W-1:0]  count_nxt;
   logic [IDX_W-1:0]  push_idx;
   logic [IDX_W-1:0]  top_idx;
   logic              full;
   logic              empty;
   logic              push;
   logic              ovf_set;
   logic              unf_set;
   logic              ovf_r;
   logic              unf_r;

   assign full     = (count_r == CNT_W'(STACK_DEPTH));
   assign empty    = (count_r == '0);
   assign push_idx = IDX_W'(count_r);
   assign top_idx  = IDX_W'(count_r - CNT_W'(1));

   always_comb begin
      pc_nxt    = pc_r;
      count_nxt = count_r;
      push      = 1'b0;
      ovf_set   = 1'b0;
      unf_set   = 1'b0;
      case (cmd)
         CMD_INC:    pc_nxt = pc_inc;
         CMD_BRANCH: pc_nxt = wrap_add(pc_r, offset_s);
         CMD_JUMP:   pc_nxt = bus.target;
         CMD_CALL: begin
            pc_nxt = bus.target;
            if (full) begin
               ovf_set = 1'b1;
            end else begin
               push      = 1'b1;
               count_nxt = count_r + CNT_W'(1);
            end
         end
         CMD_RET: begin
            if (empty) begin
               unf_set = 1'b1;
            end else begin
               pc_nxt    = stack_mem[top_idx];
               count_nxt = count_r - CNT_W'(1);
            end
         end
         default: pc_nxt = pc_r;
      endcase
   end

   // Stack storage carries no reset: entries at or above count are never read.
   always_ff @(negedge clk) begin
      if (push) stack_mem[push_idx] <= pc_inc;
   end

   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         count_r <= '0;
         ovf_r   <= 1'b0;
         unf_r   <= 1'b0;
      end else begin
         count_r <= count_nxt;
         // A new error in the same cycle as clear_err keeps the flag set.
         if (ovf_set)            ovf_r <= 1'b1;
         else if (bus.clear_err) ovf_r <= 1'b0;
         if (unf_set)            unf_r <= 1'b1;
         else if (bus.clear_err) unf_r <= 1'b0;
      end
   end

   assign bus.stack_count = count_r;
   assign bus.stack_full  = full;
   assign bus.stack_empty = empty;
   assign bus.overflow    = ovf_r;
   assign bus.underflow   = unf_r;

   a_count_bound: assert property (@(negedge clk) disable iff (reset)
      count_r <= CNT_W'(STACK_DEPTH));
   a_full_empty_excl: assert property (@(negedge clk) disable iff (reset)
      !(full && empty));
`else
   logic unused_clear_err;

   assign unused_clear_err = bus.clear_err;

   // Without a stack, call degenerates to jump and ret leaves pc untouched.
   always_comb begin
      pc_nxt = pc_r;
      case (cmd)
         CMD_INC:    pc_nxt = pc_inc;
         CMD_BRANCH: pc_nxt = wrap_add(pc_r, offset_s);
         CMD_JUMP:   pc_nxt = bus.target;
         CMD_CALL:   pc_nxt = bus.target;
         CMD_RET:    pc_nxt = pc_r;
         default:    pc_nxt = pc_r;
      endcase
   end

   assign bus.stack_count = '0;
   assign bus.stack_full  = 1'b0;
   assign bus.stack_empty = 1'b1;
   assign bus.overflow    = 1'b0;
   assign bus.underflow   = 1'b0;
`endif

   always_ff @(negedge clk or posedge reset) begin
      if (reset) pc_r <= RESET_ADDR;
      else       pc_r <= pc_nxt;
   end

   assign bus.pc = pc_r;
endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer; stack cases run only when PC_RETURN_STACK_EN is defined.
module tb_program_sequencer;
   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   program_sequencer_if #(.ADDR_W(8), .STACK_DEPTH(4)) bus ();

   program_sequencer #(.ADDR_W(8), .RESET_ADDR(8'h00), .STACK_DEPTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_cmds();
      bus.enable_increment = 1'b0;
      bus.jump             = 1'b0;
      bus.branch           = 1'b0;
      bus.call             = 1'b0;
      bus.ret              = 1'b0;
      bus.clear_err        = 1'b0;
      bus.target           = 8'h00;
      bus.offset           = 8'h00;
   endtask

   // Apply one command vector across a falling edge, then sample 2 time units later.
   task automatic issue(input logic r, input logic c, input logic j, input logic b,
                        input logic i, input logic ce, input logic [7:0] tgt,
                        input logic [7:0] off);
      bus.ret              = r;
      bus.call             = c;
      bus.jump             = j;
      bus.branch           = b;
      bus.enable_increment = i;
      bus.clear_err        = ce;
      bus.target           = tgt;
      bus.offset           = off;
      @(negedge clk);
      #2;
      clear_cmds();
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      clear_cmds();
      reset = 1'b1;
      #3;
      check_val("rst_pc",    32'(bus.pc), 32'h00);
      check_val("rst_count", 32'(bus.stack_count), 32'h0);
      check_val("rst_empty", 32'(bus.stack_empty), 32'h1);
      check_val("rst_full",  32'(bus.stack_full), 32'h0);
      check_val("rst_ovf",   32'(bus.overflow), 32'h0);
      check_val("rst_unf",   32'(bus.underflow), 32'h0);
      #4 reset = 1'b0;

      // Mid-count asynchronous reset
      issue(0, 0, 1, 0, 0, 0, 8'h37, 8'h00);
      check_val("jump_37", 32'(bus.pc), 32'h37);
      reset = 1'b1;
      #1;
      check_val("async_rst_pc", 32'(bus.pc), 32'h00);
      #1 reset = 1'b0;
      issue(0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
      check_val("inc_1", 32'(bus.pc), 32'h01);
      issue(0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
      issue(0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
      check_val("inc_3", 32'(bus.pc), 32'h03);
      issue(0, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      check_val("hold", 32'(bus.pc), 32'h03);

      // Wrap-around and signed branch
      issue(0, 0, 1, 0, 0, 0, 8'hFF, 8'h00);
      issue(0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
      check_val("inc_wrap", 32'(bus.pc), 32'h00);
      issue(0, 0, 1, 0, 0, 0, 8'h02, 8'h00);
      issue(0, 0, 0, 1, 0, 0, 8'h00, 8'hFC);
      check_val("branch_back", 32'(bus.pc), 32'hFE);
      issue(0, 0, 0, 1, 0, 0, 8'h00, 8'h05);
      check_val("branch_fwd_wrap", 32'(bus.pc), 32'h03);

      // Priority among non-stack commands
      issue(0, 0, 1, 1, 1, 0, 8'h55, 8'h01);
      check_val("jump_over_branch", 32'(bus.pc), 32'h55);
      issue(0, 0, 0, 1, 1, 0, 8'h00, 8'h02);
      check_val("branch_over_inc", 32'(bus.pc), 32'h57);

`ifdef PC_RETURN_STACK_EN
      // Simple call / return
      issue(0, 0, 1, 0, 0, 0, 8'h10, 8'h00);
      issue(0, 1, 0, 0, 0, 0, 8'h40, 8'h00);
      check_val("call_pc",    32'(bus.pc), 32'h40);
      check_val("call_count", 32'(bus.stack_count), 32'h1);
      check_val("call_empty", 32'(bus.stack_empty), 32'h0);
      issue(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      check_val("ret_pc",    32'(bus.pc), 32'h11);
      check_val("ret_count", 32'(bus.stack_count), 32'h0);
      check_val("ret_empty", 32'(bus.stack_empty), 32'h1);

      // Nesting to overflow: pushes 01, A1, A2, A3
      issue(0, 0, 1, 0, 0, 0, 8'h00, 8'h00);
      issue(0, 1, 0, 0, 0, 0, 8'hA0, 8'h00);
      issue(0, 1, 0, 0, 0, 0, 8'hA1, 8'h00);
      issue(0, 1, 0, 0, 0, 0, 8'hA2, 8'h00);
      issue(0, 1, 0, 0, 0, 0, 8'hA3, 8'h00);
      check_val("full_4",  32'(bus.stack_full), 32'h1);
      check_val("ovf_pre", 32'(bus.overflow), 32'h0);
      issue(0, 1, 0, 0, 0, 0, 8'hA4, 8'h00);
      check_val("ovf_pc",    32'(bus.pc), 32'hA4);
      check_val("ovf_flag",  32'(bus.overflow), 32'h1);
      check_val("ovf_count", 32'(bus.stack_count), 32'h4);
      issue(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      check_val("pop_1", 32'(bus.pc), 32'hA3);
      issue(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      check_val("pop_2", 32'(bus.pc), 32'hA2);
      issue(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      check_val("pop_3", 32'(bus.pc), 32'hA1);
      issue(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      check_val("pop_4",     32'(bus.pc), 32'h01);
      check_val("pop_empty", 32'(bus.stack_empty), 32'h1);
      issue(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      check_val("unf_pc",   32'(bus.pc), 32'h01);
      check_val("unf_flag", 32'(bus.underflow), 32'h1);
      check_val("unf_ovf_sticky", 32'(bus.overflow), 32'h1);
      issue(1, 0, 0, 0, 0, 1, 8'h00, 8'h00);
      check_val("set_wins_unf", 32'(bus.underflow), 32'h1);
      check_val("clr_ovf_same", 32'(bus.overflow), 32'h0);
      issue(0, 0, 0, 0, 0, 1, 8'h00, 8'h00);
      check_val("clr_unf", 32'(bus.underflow), 32'h0);
      check_val("clr_ovf", 32'(bus.overflow), 32'h0);

      // Ret outranks call, jump and increment
      issue(0, 0, 1, 0, 0, 0, 8'h20, 8'h00);
      issue(0, 1, 0, 0, 0, 0, 8'h30, 8'h00);
      issue(1, 1, 1, 0, 1, 0, 8'h77, 8'h00);
      check_val("ret_priority", 32'(bus.pc), 32'h21);
      check_val("ret_prio_cnt", 32'(bus.stack_count), 32'h0);
`else
      // Stack disabled: call acts as jump, ret holds
      issue(0, 0, 1, 0, 0, 0, 8'h10, 8'h00);
      issue(0, 1, 0, 0, 0, 0, 8'h20, 8'h00);
      check_val("nostk_call_pc",  32'(bus.pc), 32'h20);
      check_val("nostk_count",    32'(bus.stack_count), 32'h0);
      issue(1, 0, 0, 0, 0, 0, 8'h00, 8'h00);
      check_val("nostk_ret_pc",   32'(bus.pc), 32'h20);
      check_val("nostk_unf",      32'(bus.underflow), 32'h0);
      check_val("nostk_empty",    32'(bus.stack_empty), 32'h1);
      check_val("nostk_full",     32'(bus.stack_full), 32'h0);
      issue(0, 1, 0, 0, 0, 0, 8'h44, 8'h00);
      issue(0, 1, 0, 0, 0, 0, 8'h45, 8'h00);
      issue(0, 1, 0, 0, 0, 0, 8'h46, 8'h00);
      issue(0, 1, 0, 0, 0, 0, 8'h47, 8'h00);
      issue(0, 1, 0, 0, 0, 0, 8'h48, 8'h00);
      check_val("nostk_call5_pc", 32'(bus.pc), 32'h48);
      check_val("nostk_ovf",      32'(bus.overflow), 32'h0);
      issue(0, 0, 0, 0, 1, 0, 8'h00, 8'h00);
      check_val("nostk_inc",      32'(bus.pc), 32'h49);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
